fsk_tx_sequencer: RTL and testbench
===================================

Name: fsk_tx_sequencer

Overview:
Frame scheduler that feeds the 2-FSK modulator.
- On a start command it emits an alternating preamble, an 8-bit sync word, then N payload bytes, MSB first, one bit per symbol period.
- Payload bytes arrive on a valid/ready byte interface with a one-byte prefetch buffer.
- Outputs are the modulator data bit (x) and a modulator enable (mod_en). mod_en is wired to the modulator's active-low reset input, so the carrier is gated off outside frames.

Parameters:
SYM_LEN, 16, clock cycles per symbol (>=2)
PRE_LEN, 8, preamble length in bits (>=1)
SYNC_WORD, 8'hD3, sync pattern sent after the preamble, MSB first

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  frame request; sampled only in IDLE
frame_len  input  8  payload byte count; latched on accepted start; 0 is legal
din  input  8  payload byte
din_valid  input  1  din is valid
din_ready  output  1  sequencer accepts din this cycle (transfer = din_valid & din_ready)
x  output  1  bit to modulator
mod_en  output  1  modulator enable, high for the whole frame
busy  output  1  high in any state other than IDLE
done  output  1  1-cycle pulse on normal frame completion
underrun  output  1  1-cycle pulse when a frame is aborted for lack of data

Behaviour:
- Reset (async, active-high):
  - State IDLE; all counters, shift register and hold-buffer valid flag cleared.
  - Outputs x, mod_en, busy, done, underrun and din_ready are all 0.
- All outputs are registered. x is forced 0 whenever mod_en=0.
- Symbol timing:
  - sym_cnt runs 0..SYM_LEN-1 while busy and wraps.
  - A bit boundary occurs on the cycle with sym_cnt==SYM_LEN-1.
  - Each bit is held on x for exactly SYM_LEN cycles.
- States: IDLE, PRE, SYNC, DATA.
- IDLE:
  - start=1 latches frame_len. On the next cycle: state PRE, mod_en=1, busy=1, x=1, sym_cnt=0, bit_cnt=0.
  - start in any other state is ignored.
- PRE:
  - x alternates 1,0,1,0..., beginning with 1, for PRE_LEN bits.
  - At the last preamble boundary: load SYNC_WORD into the shift register and go to SYNC.
- SYNC:
  - Shifts SYNC_WORD out MSB first, 8 bits.
  - At the 8th boundary: if frame_len==0, frame ends. Otherwise, load the hold buffer into the shift register and go to DATA (see underrun rule).
- DATA:
  - Shifts each byte out MSB first.
  - At each byte's 8th boundary, load the next byte if bytes remain; otherwise the frame ends.
- Prefetch:
  - din_ready=1 when all of the following hold: state is SYNC or DATA, the hold buffer is empty, and fetched_cnt<frame_len.
  - A transfer fills the hold buffer and increments fetched_cnt.
  - The hold buffer empties on the same cycle its content is moved to the shift register.
  - din_ready is 0 in IDLE and PRE.
- Underrun: at a byte-load boundary with the hold buffer empty (bytes still owed):
  - Next cycle: state IDLE, mod_en=0, busy=0, x=0, underrun=1 for 1 cycle, done stays 0.
  - Any byte offered later is not accepted.
- Frame end: on the cycle after the last bit's final symbol cycle:
  - State IDLE, mod_en=0, busy=0, done=1 for 1 cycle.
  - start on that same done cycle is honoured, because the state is already IDLE.
- Frame duration: mod_en is high for exactly (PRE_LEN + 8 + 8*frame_len) * SYM_LEN cycles.
- Simultaneous events: a din transfer and a byte-load boundary in the same cycle is legal when the buffer was full. The load takes the old content and the new byte fills the buffer.
- Reset mid-frame: immediate abort. Neither done nor underrun is pulsed.

Test Plan:
1. Reset asserted mid-DATA (async, between clock edges) -> all outputs 0 immediately. After release, the first start gives a full preamble again.
2. SYM_LEN=4, frame_len=0, start -> x = 1010101011010011 (preamble, then D3), each bit 4 cycles. mod_en high for 64 cycles. done pulses at cycle 65. din_ready never 1.
3. Defaults, frame_len=2, din_valid held 1 with A5 then 3C -> bits after sync are 10100101 00111100. mod_en high for 512 cycles. Exactly 2 transfers. done=1, underrun never 1.
4. frame_len=2, supply A5 only, withhold the second byte -> A5 transmitted fully. Next cycle: underrun=1, mod_en=0, done stays 0. A later din_valid is not accepted.
5. start pulsed again during PRE and during DATA -> ignored: frame length and bitstream unchanged, only one done.
6. start held 1 continuously, frame_len=1 -> back-to-back frames. The second frame begins the cycle after done. The preamble restarts with x=1.

Source files
------------

// File: rtl/fsk_tx_sequencer.sv
// Frame scheduler for a 2-FSK modulator: alternating preamble, sync word, then
// N payload bytes MSB first, one bit per SYM_LEN-cycle symbol, with a one-byte prefetch buffer.
module fsk_tx_sequencer #(
    parameter int unsigned SYM_LEN   = 16,
    parameter int unsigned PRE_LEN   = 8,
    parameter logic [7:0]  SYNC_WORD = 8'hD3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       x,
    output logic       mod_en,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int unsigned SYM_W = $clog2(SYM_LEN);
    localparam int unsigned BIT_W = $clog2((PRE_LEN > 8) ? PRE_LEN : 8);

    localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(SYM_LEN - 1);
    localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PRE_LEN - 1);
    localparam logic [BIT_W-1:0] BYTE_LAST = BIT_W'(7);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_SYNC,
        S_DATA
    } state_t;

    state_t           r_state;
    logic [SYM_W-1:0] r_sym_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_hold;
    logic             r_hold_valid;
    logic [7:0]       r_len;
    logic [7:0]       r_fetched;
    logic [7:0]       r_loaded;

    logic r_x;
    logic r_mod_en;
    logic r_busy;
    logic r_done;
    logic r_underrun;
    logic r_din_ready;

    logic       w_streaming;
    logic       w_boundary;
    logic       w_xfer;
    logic       w_pre_end;
    logic       w_byte_end;
    logic       w_bytes_owed;
    logic       w_load;
    logic       w_underrun;
    logic       w_frame_end;
    logic       w_hold_valid_nx;
    logic [7:0] w_fetched_nx;
    logic       w_stream_nx;
    logic       w_ready_nx;

    assign w_streaming  = (r_state == S_SYNC) || (r_state == S_DATA);
    assign w_boundary   = (r_state != S_IDLE) && (r_sym_cnt == SYM_LAST);
    assign w_xfer       = din_valid && r_din_ready;
    assign w_pre_end    = w_boundary && (r_state == S_PRE) && (r_bit_cnt == PRE_LAST);
    assign w_byte_end   = w_boundary && w_streaming && (r_bit_cnt == BYTE_LAST);
    assign w_bytes_owed = (r_loaded != r_len);
    assign w_load       = w_byte_end && w_bytes_owed && r_hold_valid;
    assign w_underrun   = w_byte_end && w_bytes_owed && !r_hold_valid;
    assign w_frame_end  = w_byte_end && !w_bytes_owed;

    // A load and a transfer on the same edge leave the buffer full with the new byte.
    assign w_hold_valid_nx = w_xfer || (r_hold_valid && !w_load);
    assign w_fetched_nx    = r_fetched + {7'd0, w_xfer};

    // din_ready is registered, so it is computed from next-cycle state and buffer contents.
    assign w_stream_nx = w_pre_end || (w_streaming && !w_underrun && !w_frame_end);
    assign w_ready_nx  = w_stream_nx && !w_hold_valid_nx && (w_fetched_nx < r_len);

    // NOTE: sequential state uses non-blocking assignments only, so every read
    // in this block sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sym_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_len        <= '0;
            r_fetched    <= '0;
            r_loaded     <= '0;
            r_x          <= 1'b0;
            r_mod_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
            r_din_ready  <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
            r_din_ready  <= w_ready_nx;
            r_hold_valid <= w_hold_valid_nx;
            if (w_xfer) begin
                r_hold    <= din;
                r_fetched <= w_fetched_nx;
            end

            if (r_state == S_IDLE) begin
                if (start) begin
                    r_state      <= S_PRE;
                    r_len        <= frame_len;
                    r_fetched    <= '0;
                    r_loaded     <= '0;
                    r_hold_valid <= 1'b0;
                    r_sym_cnt    <= '0;
                    r_bit_cnt    <= '0;
                    r_x          <= 1'b1;
                    r_mod_en     <= 1'b1;
                    r_busy       <= 1'b1;
                end
            end else if (w_underrun || w_frame_end) begin
                r_state    <= S_IDLE;
                r_sym_cnt  <= '0;
                r_bit_cnt  <= '0;
                r_x        <= 1'b0;
                r_mod_en   <= 1'b0;
                r_busy     <= 1'b0;
                r_done     <= w_frame_end;
                r_underrun <= w_underrun;
            end else begin
                r_sym_cnt <= w_boundary ? '0 : r_sym_cnt + SYM_W'(1);
                if (w_boundary) begin
                    if (r_state == S_PRE) begin
                        if (w_pre_end) begin
                            r_state   <= S_SYNC;
                            r_shift   <= SYNC_WORD;
                            r_x       <= SYNC_WORD[7];
                            r_bit_cnt <= '0;
                        end else begin
                            r_x       <= ~r_x;
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end else if (w_load) begin
                        r_state   <= S_DATA;
                        r_shift   <= r_hold;
                        r_x       <= r_hold[7];
                        r_loaded  <= r_loaded + 8'd1;
                        r_bit_cnt <= '0;
                    end else begin
                        r_shift   <= {r_shift[6:0], 1'b0};
                        r_x       <= r_shift[6];
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    end
                end
            end
        end
    end

    assign x         = r_x;
    assign mod_en    = r_mod_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign underrun  = r_underrun;
    assign din_ready = r_din_ready;

endmodule

// File: tb/tb_fsk_tx_sequencer.sv
// Bench for fsk_tx_sequencer: a default instance and a SYM_LEN=4 instance, each checked
// cycle by cycle against a bit-stream / buffer-occupancy model built from the frame rules.
module tb_fsk_tx_sequencer;

    localparam int         PRE  = 8;
    localparam logic [7:0] SYNC = 8'hD3;

    logic       clk = 1'b0;
    logic       rst     [2];
    logic       start_s [2];
    logic [7:0] flen    [2];
    logic [7:0] din_s   [2];
    logic       dval    [2];
    logic       rdy     [2];
    logic       xo      [2];
    logic       men     [2];
    logic       bsy     [2];
    logic       dn      [2];
    logic       ur      [2];

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] sup[$];
    bit         exp_bits[$];

    always #5 clk = ~clk;

    fsk_tx_sequencer u_dut16 (
        .clk(clk), .reset(rst[0]), .start(start_s[0]), .frame_len(flen[0]),
        .din(din_s[0]), .din_valid(dval[0]), .din_ready(rdy[0]), .x(xo[0]),
        .mod_en(men[0]), .busy(bsy[0]), .done(dn[0]), .underrun(ur[0])
    );

    fsk_tx_sequencer #(.SYM_LEN(4), .PRE_LEN(PRE), .SYNC_WORD(SYNC)) u_dut4 (
        .clk(clk), .reset(rst[1]), .start(start_s[1]), .frame_len(flen[1]),
        .din(din_s[1]), .din_valid(dval[1]), .din_ready(rdy[1]), .x(xo[1]),
        .mod_en(men[1]), .busy(bsy[1]), .done(dn[1]), .underrun(ur[1])
    );

    function automatic int sym_of(input int d);
        return (d == 0) ? 16 : 4;
    endfunction

    task automatic check(input string name, input int k, input string what,
                         input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d %s: observed %b expected %b", name, k, what, obs, exp);
        end
    endtask

    task automatic check_outputs(input int d, input string name, input int k,
                                 input logic e_x, input logic e_men, input logic e_done,
                                 input logic e_ur, input logic e_rdy);
        check(name, k, "x",         xo[d],  e_x);
        check(name, k, "mod_en",    men[d], e_men);
        check(name, k, "busy",      bsy[d], e_men);
        check(name, k, "done",      dn[d],  e_done);
        check(name, k, "underrun",  ur[d],  e_ur);
        check(name, k, "din_ready", rdy[d], e_rdy);
    endtask

    task automatic idle_check(input int d, input int n, input logic v, input string name);
        for (int i = 0; i < n; i++) begin
            dval[d]  = v;
            din_s[d] = 8'($urandom);
            @(negedge clk);
            check_outputs(d, name, i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        dval[d] = 1'b0;
    endtask

    // Called just after a negedge. Returns at the negedge of the done/underrun cycle
    // (or right after an injected reset). Bytes to offer are taken from sup[].
    task automatic run_frame(input int d, input int len, input bit hold_start,
                             input int gap_pct, input int pulse_k1, input int pulse_k2,
                             input int rst_k, input string name);
        int  sym;
        int  end_k;
        bit  aborted;
        bit  hold_full;
        int  fetched;
        int  sidx;
        bit  e_men;
        bit  e_rdy;
        sym = sym_of(d);
        exp_bits.delete();
        for (int i = 0; i < PRE; i++) exp_bits.push_back(i % 2 == 0);
        for (int b = 7; b >= 0; b--) exp_bits.push_back(SYNC[b]);
        for (int j = 0; j < len && j < sup.size(); j++) begin
            automatic logic [7:0] by = sup[j];
            for (int b = 7; b >= 0; b--) exp_bits.push_back(by[b]);
        end
        end_k     = (PRE + 8 + 8 * len) * sym;
        aborted   = 1'b0;
        hold_full = 1'b0;
        fetched   = 0;
        sidx      = 0;
        start_s[d] = 1'b1;
        flen[d]    = 8'(len);
        for (int k = 0; k < 60000; k++) begin
            @(negedge clk);
            e_men = (k < end_k);
            e_rdy = e_men && (k >= PRE * sym) && !hold_full && (fetched < len);
            check_outputs(d, name, k, e_men ? exp_bits[k / sym] : 1'b0, e_men,
                          (k == end_k) && !aborted, (k == end_k) && aborted, e_rdy);
            if (k == end_k) begin
                dval[d] = 1'b0;
                break;
            end
            if (k == rst_k) begin
                #2 rst[d] = 1'b1;
                #1 check_outputs(d, name, k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                check_outputs(d, name, k + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                rst[d]     = 1'b0;
                dval[d]    = 1'b0;
                start_s[d] = 1'b0;
                break;
            end
            if (!hold_start) start_s[d] = (k == pulse_k1) || (k == pulse_k2);
            flen[d]  = 8'($urandom);
            dval[d]  = (sidx < sup.size()) && ($urandom_range(0, 99) >= gap_pct);
            din_s[d] = dval[d] ? sup[sidx] : 8'($urandom);
            // Byte j is due at the end of bit PRE+8+8j-1; an empty buffer there aborts.
            if ((k + 1) % sym == 0) begin
                automatic int b = (k + 1) / sym;
                if (b >= PRE + 8 && (b - PRE - 8) % 8 == 0 && (b - PRE - 8) / 8 < len) begin
                    if (hold_full) begin
                        hold_full = 1'b0;
                    end else begin
                        aborted = 1'b1;
                        end_k   = k + 1;
                    end
                end
            end
            if (dval[d] && e_rdy) begin
                hold_full = 1'b1;
                fetched++;
                sidx++;
            end
        end
    endtask

    task automatic random_bytes(input int n);
        sup.delete();
        for (int i = 0; i < n; i++) sup.push_back(8'($urandom));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; start_s[d] = 1'b0; flen[d] = '0; din_s[d] = '0; dval[d] = 1'b0;
        end
        #2;
        for (int d = 0; d < 2; d++)
            check_outputs(d, "reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        idle_check(1, 2, 1'b0, "post_reset");

        // Empty payload: preamble + sync only, ready never raised.
        sup.delete();
        run_frame(1, 0, 1'b0, 0, -1, -1, -1, "len0");
        idle_check(1, 3, 1'b0, "len0_idle");

        // Default timing, two bytes offered back to back.
        sup.delete();
        sup.push_back(8'hA5);
        sup.push_back(8'h3C);
        run_frame(0, 2, 1'b0, 0, -1, -1, -1, "def_len2");
        idle_check(0, 3, 1'b0, "def_idle");

        // Second byte withheld: underrun after A5, later offers refused.
        sup.delete();
        sup.push_back(8'hA5);
        run_frame(1, 2, 1'b0, 0, -1, -1, -1, "underrun");
        idle_check(1, 10, 1'b1, "after_underrun");

        // Stray start pulses in PRE and DATA are ignored.
        random_bytes(3);
        run_frame(1, 3, 1'b0, 30, 5, (PRE + 8 + 4) * 4, -1, "stray_start");
        idle_check(1, 3, 1'b0, "stray_idle");

        // start held high: frames follow one another directly after done.
        for (int f = 0; f < 3; f++) begin
            random_bytes(1);
            run_frame(1, 1, 1'b1, 0, -1, -1, -1, "back2back");
        end
        start_s[1] = 1'b0;
        idle_check(1, 3, 1'b0, "b2b_idle");

        // Asynchronous reset in the middle of DATA, then a clean frame.
        random_bytes(3);
        run_frame(1, 3, 1'b0, 20, -1, -1, (PRE + 8 + 8 + 3) * 4 + 1, "mid_reset");
        idle_check(1, 3, 1'b0, "mid_reset_idle");
        random_bytes(1);
        run_frame(1, 1, 1'b0, 0, -1, -1, -1, "after_reset");
        idle_check(1, 2, 1'b0, "after_reset_idle");

        // Randomized frames: random lengths, payloads and valid gaps.
        for (int i = 0; i < 6; i++) begin
            automatic int len = $urandom_range(0, 5);
            random_bytes(len);
            run_frame(1, len, 1'b0, $urandom_range(0, 60), -1, -1, -1, "rand4");
            idle_check(1, $urandom_range(1, 3), 1'b0, "rand4_idle");
        end
        begin
            automatic int len = $urandom_range(1, 3);
            random_bytes(len);
            run_frame(0, len, 1'b0, 50, -1, -1, -1, "rand16");
            idle_check(0, 2, 1'b0, "rand16_idle");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
